// File: rtl/hazard_pkg.sv
// Shared pipeline-hazard constants: depth, T_new/T_use encodings.
// Imported by the scoreboard interface, entry and top.
package hazard_pkg;

  localparam int DEPTH = 3;
  localparam int TW    = 2;
  localparam int WBW   = 2;

  typedef logic [TW-1:0]  t_cnt_t;
  typedef logic [WBW-1:0] wb_cnt_t;
  typedef logic [4:0]     reg_idx_t;

  localparam t_cnt_t TNEW_NONE = 2'd0;
  localparam t_cnt_t TNEW_ALU  = 2'd1;
  localparam t_cnt_t TNEW_LOAD = 2'd2;

  localparam t_cnt_t TUSE_BRANCH     = 2'd0;
  localparam t_cnt_t TUSE_ALU        = 2'd1;
  localparam t_cnt_t TUSE_STORE_DATA = 2'd2;
  localparam t_cnt_t TUSE_NONE       = 2'd3;

endpackage

// File: rtl/grf_scoreboard_if.sv
// Scoreboard bundle: pipeline control, issue, D-stage reads, stall/busy.
// master = decode/pipeline control side, slave = grf_scoreboard.
interface grf_scoreboard_if;
  import hazard_pkg::*;

  logic     pipe_move;
  logic     flush;
  logic     issue_valid;
  reg_idx_t issue_rd;
  t_cnt_t   issue_tnew;
  reg_idx_t rs_num;
  reg_idx_t rt_num;
  t_cnt_t   rs_tuse;
  t_cnt_t   rt_tuse;
  logic        stall;
  logic [31:0] busy;

  modport master (
    output pipe_move, flush, issue_valid, issue_rd, issue_tnew,
    output rs_num, rt_num, rs_tuse, rt_tuse,
    input  stall, busy
  );

  modport slave (
    input  pipe_move, flush, issue_valid, issue_rd, issue_tnew,
    input  rs_num, rt_num, rs_tuse, rt_tuse,
    output stall, busy
  );

endinterface

// File: rtl/grf_scoreboard_entry.sv
// One register's writer entry: valid, forward countdown, commit countdown.
// Ports: clk, reset, flush, load, move, tnew in; v_o, rdy_o out.
module sb_entry
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   load,
  input  logic   move,
  input  t_cnt_t tnew,
  output logic   v_o,
  output t_cnt_t rdy_o
);

  logic    v_q, v_d;
  t_cnt_t  rc_q, rc_d;
  wb_cnt_t wb_q, wb_d;

  always_comb begin
    v_d  = v_q;
    rc_d = rc_q;
    wb_d = wb_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d  = 1'b1;
      rc_d = tnew;
      wb_d = WBW'(DEPTH);
    end else if (move && v_q) begin
      rc_d = (rc_q != '0) ? rc_q - t_cnt_t'(1) : '0;
      wb_d = wb_q - wb_cnt_t'(1);
      // last move: write commits now, RF bypass covers readers
      if (wb_q == wb_cnt_t'(1)) v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= 1'b0;
      rc_q <= '0;
      wb_q <= '0;
    end else begin
      v_q  <= v_d;
      rc_q <= rc_d;
      wb_q <= wb_d;
    end
  end

  assign v_o   = v_q;
  assign rdy_o = rc_q;

endmodule

// File: rtl/grf_scoreboard.sv
// RAW hazard scoreboard beside decode; raises D-stage stall.
// Ports: clk, reset, sb (slave: issue/read inputs, stall/busy outputs).
module grf_scoreboard
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  grf_scoreboard_if.slave sb
);

  logic [31:0] v_vec;
  t_cnt_t      rc [32];
  logic        issue_en;
  logic        rs_haz;
  logic        rt_haz;

  // a frozen pipe never accepts an issue
  assign issue_en = sb.issue_valid && sb.pipe_move
                 && (sb.issue_rd != '0);

  assign v_vec[0] = 1'b0;
  assign rc[0]    = '0;

  for (genvar r = 1; r < 32; r++) begin : g_ent
    logic ld;
    assign ld = issue_en && (sb.issue_rd == 5'(r));
    sb_entry u_ent (
      .clk   (clk),
      .reset (reset),
      .flush (sb.flush),
      .load  (ld),
      .move  (sb.pipe_move),
      .tnew  (sb.issue_tnew),
      .v_o   (v_vec[r]),
      .rdy_o (rc[r])
    );
  end

  assign rs_haz = (sb.rs_num != '0) && v_vec[sb.rs_num]
               && (rc[sb.rs_num] > sb.rs_tuse);
  assign rt_haz = (sb.rt_num != '0) && v_vec[sb.rt_num]
               && (rc[sb.rt_num] > sb.rt_tuse);

  assign sb.stall = rs_haz || rt_haz;
  assign sb.busy  = v_vec;

  a_issue_frozen: assert property (
    @(posedge clk) disable iff (reset)
    !(sb.issue_valid && !sb.pipe_move)
  );

endmodule
